gtx_8x10enc_par: RTL

Parametrised 8b/10b encoder for the GTX transmit path, successor to the fixed two-byte table-based encoder. Encodes BYTES characters per clock with logic-only 5b/6b and 3b/4b sub-block encoding, so no block RAM is used. Carries running disparity across bytes and words, and supports per-byte forced disparity. Flags illegal control characters. Sits between the link-layer TX datapath and the GTX TXDATA port, with a valid-qualified two-stage pipeline.

---
 rtl/gtx_8x10enc_par.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/gtx_8x10enc_par.sv
// gtx_8x10enc_par: logic-only 8b/10b encoder, BYTES characters per clock.
// Stage 1 precomputes both-disparity sub-blocks, stage 2 chains disparity.
module gtx_8x10enc_par #(
  parameter int BYTES   = 2,
  parameter int CHECK_K = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [BYTES-1:0]    inisk,
  input  logic [8*BYTES-1:0]  indata,
  input  logic [BYTES-1:0]    force_en,
  input  logic [BYTES-1:0]    force_val,
  output logic                out_valid,
  output logic [10*BYTES-1:0] outdata,
  output logic                out_disp,
  output logic [BYTES-1:0]    k_err
);

  typedef struct packed {
    logic [5:0] c6n;
    logic [5:0] c6p;
    logic       n6;
    logic [3:0] c4n;
    logic [3:0] c4p;
    logic       n4;
    logic       kerr;
    logic       fen;
    logic       fval;
  } s1_t;

  // RD- column, abcdei with a in the MSB
  function automatic logic [5:0] tab6(input logic [4:0] x);
    logic [5:0] c;
    case (x)
      5'd0:    c = 6'b100111;
      5'd1:    c = 6'b011101;
      5'd2:    c = 6'b101101;
      5'd3:    c = 6'b110001;
      5'd4:    c = 6'b110101;
      5'd5:    c = 6'b101001;
      5'd6:    c = 6'b011001;
      5'd7:    c = 6'b111000;
      5'd8:    c = 6'b111001;
      5'd9:    c = 6'b100101;
      5'd10:   c = 6'b010101;
      5'd11:   c = 6'b110100;
      5'd12:   c = 6'b001101;
      5'd13:   c = 6'b101100;
      5'd14:   c = 6'b011100;
      5'd15:   c = 6'b010111;
      5'd16:   c = 6'b011011;
      5'd17:   c = 6'b100011;
      5'd18:   c = 6'b010011;
      5'd19:   c = 6'b110010;
      5'd20:   c = 6'b001011;
      5'd21:   c = 6'b101010;
      5'd22:   c = 6'b011010;
      5'd23:   c = 6'b111010;
      5'd24:   c = 6'b110011;
      5'd25:   c = 6'b100110;
      5'd26:   c = 6'b010110;
      5'd27:   c = 6'b110110;
      5'd28:   c = 6'b001110;
      5'd29:   c = 6'b101110;
      5'd30:   c = 6'b011110;
      default: c = 6'b101011;
    endcase
    return c;
  endfunction

  // RD- column, fghj with f in the MSB; y=7 is the primary form
  function automatic logic [3:0] tab4(input logic [2:0] y);
    logic [3:0] c;
    case (y)
      3'd0:    c = 4'b1011;
      3'd1:    c = 4'b1001;
      3'd2:    c = 4'b0101;
      3'd3:    c = 4'b1100;
      3'd4:    c = 4'b1101;
      3'd5:    c = 4'b1010;
      3'd6:    c = 4'b0110;
      default: c = 4'b1110;
    endcase
    return c;
  endfunction

  function automatic logic [5:0] rev6(input logic [5:0] v);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = v[5-i];
    return r;
  endfunction

  function automatic logic [3:0] rev4(input logic [3:0] v);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = v[3-i];
    return r;
  endfunction

  function automatic s1_t pre(
    input logic [7:0] b,
    input logic       k,
    input logic       fe,
    input logic       fv
  );
    s1_t        s;
    logic [4:0] x;
    logic [2:0] y;
    logic       kl;
    logic       k28;
    logic       k7;
    logic       d7;
    logic       nb;
    logic       a7n;
    logic       a7p;
    logic [5:0] c6;
    logic [3:0] c4;
    logic [3:0] c4n;
    logic [3:0] c4p;
    x   = b[4:0];
    y   = b[7:5];
    kl  = (x == 5'd28) ||
          ((y == 3'd7) &&
           (x == 5'd23 || x == 5'd27 ||
            x == 5'd29 || x == 5'd30));
    k28 = k && kl && (x == 5'd28);
    k7  = k && kl && (y == 3'd7);
    c6  = k28 ? 6'b001111 : tab6(x);
    d7  = !k28 && (x == 5'd7);
    s.n6  = ($countones(c6) == 3);
    s.c6n = rev6(c6);
    s.c6p = rev6((s.n6 && !d7) ? c6 : ~c6);
    c4  = tab4(y);
    nb  = (y == 3'd1) || (y == 3'd2) ||
          (y == 3'd5) || (y == 3'd6);
    a7n = (x == 5'd17) || (x == 5'd18) ||
          (x == 5'd20);
    a7p = (x == 5'd11) || (x == 5'd13) ||
          (x == 5'd14);
    s.n4 = nb || (y == 3'd3);
    // K28 neutral 4b codes are the complements of the data forms
    if (k7 || (y == 3'd7 && a7n))
      c4n = 4'b0111;
    else if (k28 && nb)
      c4n = ~c4;
    else
      c4n = c4;
    if (k7 || (y == 3'd7 && a7p))
      c4p = 4'b1000;
    else if (nb)
      c4p = c4;
    else
      c4p = ~c4;
    s.c4n  = rev4(c4n);
    s.c4p  = rev4(c4p);
    s.kerr = (CHECK_K != 0) && k && !kl;
    s.fen  = fe;
    s.fval = fv;
    return s;
  endfunction

  s1_t [BYTES-1:0]     s1_d;
  s1_t [BYTES-1:0]     s1_q;
  logic                s1_v;
  logic                rd_q;
  logic                rd_d;
  logic                rd_c;
  logic [10*BYTES-1:0] enc_d;
  logic [BYTES-1:0]    kerr_d;

  always_comb begin
    s1_d = '0;
    for (int i = 0; i < BYTES; i++)
      s1_d[i] = pre(indata[8*i +: 8], inisk[i],
                    force_en[i], force_val[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_q <= '0;
    end else begin
      s1_v <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  // rd_q is already updated by the previous word when this one arrives
  always_comb begin
    rd_c   = rd_q;
    enc_d  = '0;
    kerr_d = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (s1_q[i].fen) rd_c = s1_q[i].fval;
      enc_d[10*i +: 6] = rd_c ? s1_q[i].c6p : s1_q[i].c6n;
      rd_c = rd_c ^ !s1_q[i].n6;
      enc_d[10*i+6 +: 4] = rd_c ? s1_q[i].c4p : s1_q[i].c4n;
      rd_c = rd_c ^ !s1_q[i].n4;
      kerr_d[i] = s1_q[i].kerr;
    end
    rd_d = rd_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      outdata   <= '0;
      rd_q      <= 1'b0;
      k_err     <= '0;
    end else begin
      out_valid <= s1_v;
      k_err     <= s1_v ? kerr_d : '0;
      if (s1_v) begin
        outdata <= enc_d;
        rd_q    <= rd_d;
      end
    end
  end

  assign out_disp = rd_q;

endmodule
